// File: rtl/fir_y_stream_packer.sv
// fir_y_stream_packer: packs the FIR y stream for an AXI-stream master.
// Each input sample is arithmetically right-shifted by a per-frame amount and
// saturated to pOUT_WIDTH. Results go through a small first-word-fall-through
// FIFO and are re-emitted with m_tlast on the cfg_len-th sample of the frame.
//
// Ports:
//   axis_clk, axis_rst     clock, synchronous active-high reset
//   cfg_start              pulse in idle: latch cfg_len/cfg_shift, start a frame
//   cfg_len, cfg_shift     samples per frame, arithmetic right shift amount
//   s_tvalid/s_tdata/s_tready  y sample input (slave side)
//   m_tvalid/m_tdata/m_tlast/m_tready  scaled sample output (master side)
//   busy                   frame in progress (streaming or draining)
//   frame_done             one-cycle pulse after the tlast beat is accepted
//   overrun                sticky: a sample was offered outside the streaming phase
//   sat_cnt                saturation events this frame, saturating at 0xFFFF
module fir_y_stream_packer #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pOUT_WIDTH  = 16,
  parameter int unsigned pFIFO_DEPTH = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  input  logic [4:0]             cfg_shift,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pOUT_WIDTH-1:0]  m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [15:0]            sat_cnt
);

  localparam int unsigned AW = $clog2(pFIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             len_q, len_d;
  logic [4:0]              shift_q, shift_d;
  logic [31:0]             in_cnt_q, in_cnt_d;
  logic [15:0]             sat_cnt_q, sat_cnt_d;
  logic                    overrun_q, overrun_d;

  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [pOUT_WIDTH-1:0]   mem_data_q [pFIFO_DEPTH];
  logic                    mem_last_q [pFIFO_DEPTH];

  logic                    fifo_empty, fifo_full;
  logic                    in_beat, out_beat, in_last;
  logic signed [pDATA_WIDTH-1:0] shifted;
  logic                    sat_pos, sat_neg;
  logic [pOUT_WIDTH-1:0]   sat_val;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(pFIFO_DEPTH));

  assign s_tready   = (state_q == StStream) && !fifo_full;
  assign in_beat    = s_tvalid && s_tready;
  assign m_tvalid   = !fifo_empty;
  // Gate the head with empty so outputs read as zero rather than stale entries.
  assign m_tdata    = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
  assign m_tlast    = fifo_empty ? 1'b0 : mem_last_q[rd_ptr_q];
  assign out_beat   = m_tvalid && m_tready;

  assign busy       = (state_q == StStream) || (state_q == StDrain);
  assign frame_done = (state_q == StDone);
  assign overrun    = overrun_q;
  assign sat_cnt    = sat_cnt_q;

  assign in_last    = (in_cnt_q == len_q - 32'd1);

  // Saturate when the bits above the output sign bit are not a pure sign extension.
  assign shifted = $signed(s_tdata) >>> shift_q;
  assign sat_pos = !shifted[pDATA_WIDTH-1] && (|shifted[pDATA_WIDTH-2:pOUT_WIDTH-1]);
  assign sat_neg = shifted[pDATA_WIDTH-1] && !(&shifted[pDATA_WIDTH-2:pOUT_WIDTH-1]);

  always_comb begin
    sat_val = shifted[pOUT_WIDTH-1:0];
    if (sat_pos) begin
      sat_val = {1'b0, {(pOUT_WIDTH-1){1'b1}}};
    end else if (sat_neg) begin
      sat_val = {1'b1, {(pOUT_WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    shift_d   = shift_q;
    in_cnt_d  = in_cnt_q;
    sat_cnt_d = sat_cnt_q;
    overrun_d = overrun_q;

    if (s_tvalid && (state_q != StStream)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          len_d     = cfg_len;
          shift_d   = cfg_shift;
          in_cnt_d  = '0;
          sat_cnt_d = '0;
          overrun_d = 1'b0;
          state_d   = (cfg_len == 32'd0) ? StDone : StStream;
        end
      end
      StStream: begin
        if (in_beat) begin
          in_cnt_d = in_cnt_q + 32'd1;
          if ((sat_pos || sat_neg) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
          end
          if (in_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // The tagged entry is always the last one in the FIFO.
        if (out_beat && m_tlast) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      shift_q   <= '0;
      in_cnt_q  <= '0;
      sat_cnt_q <= '0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      in_cnt_q  <= in_cnt_d;
      sat_cnt_q <= sat_cnt_d;
      overrun_q <= overrun_d;
      if (in_beat) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (out_beat) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({in_beat, out_beat})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the reset count marks every entry invalid.
  always_ff @(posedge axis_clk) begin
    if (in_beat) begin
      mem_data_q[wr_ptr_q] <= sat_val;
      mem_last_q[wr_ptr_q] <= in_last;
    end
  end

endmodule

// File: tb/tb_fir_y_stream_packer.sv
module tb_fir_y_stream_packer;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        cfg_start;
  logic [31:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic        m_tvalid;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [15:0] sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fir_y_stream_packer #(
    .pDATA_WIDTH(32),
    .pOUT_WIDTH (16),
    .pFIFO_DEPTH(4)
  ) dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun),
    .sat_cnt   (sat_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct {
    logic [4:0]  shift;
    logic [31:0] din;
    logic [15:0] want;
    logic [15:0] want_sat;
  } vec_t;

  vec_t vecs[13];

  // Outputs are all register-derived, so sampling 1 time unit after the edge is safe.
  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic cfg(input logic [31:0] len, input logic [4:0] sh);
    cfg_start = 1'b1;
    cfg_len   = len;
    cfg_shift = sh;
    step();
    cfg_start = 1'b0;
  endtask

  // Reference: floor division by 2^sh, then clamp to the signed 16-bit range.
  task automatic ref_scale(input logic [31:0] d, input logic [4:0] sh,
                           output logic [15:0] v, output bit s);
    longint t;
    t = longint'($signed(d)) / (longint'(1) << sh);
    if (t * (longint'(1) << sh) > longint'($signed(d))) t = t - 1;
    s = 1'b0;
    if (t > 32767) begin
      v = 16'h7FFF;
      s = 1'b1;
    end else if (t < -32768) begin
      v = 16'h8000;
      s = 1'b1;
    end else begin
      v = 16'(t);
    end
  endtask

  task automatic run_frame(input logic [31:0] din[$], input logic [4:0] sh,
                           input int vprob, input int rprob);
    int          len;
    int          idx;
    int          outn;
    int          want_sat;
    bit          done;
    bit          s;
    logic [15:0] v;
    logic [16:0] ev_q[$];
    len      = din.size();
    want_sat = 0;
    for (int i = 0; i < len; i++) begin
      ref_scale(din[i], sh, v, s);
      ev_q.push_back({(i == len - 1), v});
      if (s && want_sat < 65535) want_sat++;
    end
    cfg(32'(len), sh);
    chk("start_overrun", 32'(overrun), 32'd0);
    chk("start_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("start_busy", 32'(busy), 32'(len != 0));
    idx  = 0;
    outn = 0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      s_tvalid = (idx < len) && ($urandom_range(99) < 32'(vprob));
      s_tdata  = (idx < len) ? din[idx] : 32'd0;
      m_tready = ($urandom_range(99) < 32'(rprob));
      if (frame_done) begin
        done = 1'b1;
      end else begin
        if (m_tvalid) begin
          if (outn < len) begin
            chk("beat_data", 32'(m_tdata), 32'(ev_q[outn][15:0]));
            chk("beat_last", 32'(m_tlast), 32'(ev_q[outn][16]));
          end else begin
            chk("extra_beat", 32'(m_tvalid), 32'd0);
          end
          if (m_tready) outn++;
        end
        if (s_tvalid && s_tready) idx++;
        step();
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("frame_done_seen", 32'(done), 32'd1);
    chk("beats_out", 32'(outn), 32'(len));
    chk("beats_in", 32'(idx), 32'(len));
    chk("end_sat_cnt", 32'(sat_cnt), 32'(want_sat));
    chk("end_overrun", 32'(overrun), 32'd0);
    step();
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    int          acc;
    int          outn;
    bit          seen;

    vecs[0]  = '{5'd0,  32'h0000_0005, 16'h0005, 16'd0};
    vecs[1]  = '{5'd0,  32'hFFFF_FFF9, 16'hFFF9, 16'd0};
    vecs[2]  = '{5'd0,  32'h0000_0064, 16'h0064, 16'd0};
    vecs[3]  = '{5'd4,  32'h0000_1230, 16'h0123, 16'd0};
    vecs[4]  = '{5'd0,  32'h0001_2345, 16'h7FFF, 16'd1};
    vecs[5]  = '{5'd0,  32'hFFFE_0000, 16'h8000, 16'd1};
    vecs[6]  = '{5'd16, 32'h7FFF_0000, 16'h7FFF, 16'd0};
    vecs[7]  = '{5'd31, 32'h8000_0000, 16'hFFFF, 16'd0};
    vecs[8]  = '{5'd0,  32'h0000_7FFF, 16'h7FFF, 16'd0};
    vecs[9]  = '{5'd0,  32'hFFFF_8000, 16'h8000, 16'd0};
    vecs[10] = '{5'd0,  32'h0000_8000, 16'h7FFF, 16'd1};
    vecs[11] = '{5'd1,  32'h0001_0000, 16'h7FFF, 16'd1};
    vecs[12] = '{5'd1,  32'hFFFE_FFFF, 16'h8000, 16'd1};

    axis_rst  = 1'b1;
    cfg_start = 1'b0;
    cfg_len   = '0;
    cfg_shift = '0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    m_tready  = 1'b0;
    step();
    step();
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    axis_rst = 1'b0;
    step();

    // Three-sample frame at full rate: one-cycle latency, tlast on the third.
    cfg(32'd3, 5'd0);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'd5;
    step();
    chk("t1_v0", 32'(m_tvalid), 32'd1);
    chk("t1_d0", 32'(m_tdata), 32'h0005);
    chk("t1_l0", 32'(m_tlast), 32'd0);
    s_tdata = 32'hFFFF_FFF9;
    step();
    chk("t1_d1", 32'(m_tdata), 32'hFFF9);
    chk("t1_l1", 32'(m_tlast), 32'd0);
    s_tdata = 32'd100;
    step();
    s_tvalid = 1'b0;
    chk("t1_d2", 32'(m_tdata), 32'h0064);
    chk("t1_l2", 32'(m_tlast), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_done", 32'(frame_done), 32'd1);
    chk("t1_empty", 32'(m_tvalid), 32'd0);
    step();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_done_clr", 32'(frame_done), 32'd0);
    m_tready = 1'b0;

    // Single-sample frames from the vector table.
    for (int i = 0; i < 13; i++) begin
      cfg(32'd1, vecs[i].shift);
      s_tvalid = 1'b1;
      s_tdata  = vecs[i].din;
      step();
      s_tvalid = 1'b0;
      chk("vec_valid", 32'(m_tvalid), 32'd1);
      chk("vec_data", 32'(m_tdata), 32'(vecs[i].want));
      chk("vec_last", 32'(m_tlast), 32'd1);
      chk("vec_sat", 32'(sat_cnt), 32'(vecs[i].want_sat));
      m_tready = 1'b1;
      step();
      chk("vec_done", 32'(frame_done), 32'd1);
      m_tready = 1'b0;
      step();
    end

    // Two saturating samples in one frame accumulate sat_cnt.
    q = {};
    q.push_back(32'h0001_2345);
    q.push_back(32'hFFFE_0000);
    run_frame(q, 5'd0, 100, 100);

    // Backpressure: FIFO fills after four samples, head holds, then drains in order.
    cfg(32'd8, 5'd0);
    m_tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      s_tvalid = (acc < 8);
      s_tdata  = 32'(acc * 11 + 1);
      if (s_tready) acc++;
      step();
    end
    chk("t3_accepted", 32'(acc), 32'd4);
    chk("t3_stall", 32'(s_tready), 32'd0);
    chk("t3_head", 32'(m_tdata), 32'd1);
    chk("t3_valid", 32'(m_tvalid), 32'd1);
    m_tready = 1'b1;
    outn = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      s_tvalid = (acc < 8);
      s_tdata  = 32'(acc * 11 + 1);
      if (frame_done) begin
        seen = 1'b1;
      end else begin
        if (m_tvalid) begin
          chk("t3_data", 32'(m_tdata), 32'(outn * 11 + 1));
          chk("t3_last", 32'(m_tlast), 32'(outn == 7));
          outn++;
        end
        if (s_tvalid && s_tready) acc++;
        step();
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("t3_out_count", 32'(outn), 32'd8);
    chk("t3_done_seen", 32'(seen), 32'd1);
    step();

    // Zero-length frame: immediate done, no beats, never busy.
    cfg(32'd0, 5'd0);
    chk("t4_done", 32'(frame_done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(m_tvalid), 32'd0);
    step();
    chk("t4_done_clr", 32'(frame_done), 32'd0);
    chk("t4_busy2", 32'(busy), 32'd0);

    // Sample offered while idle: rejected, sticky overrun, cleared by next start.
    s_tvalid = 1'b1;
    s_tdata  = 32'd9;
    chk("t5_ready", 32'(s_tready), 32'd0);
    step();
    s_tvalid = 1'b0;
    chk("t5_overrun", 32'(overrun), 32'd1);
    step();
    step();
    chk("t5_sticky", 32'(overrun), 32'd1);
    chk("t5_not_taken", 32'(m_tvalid), 32'd0);
    q = {};
    q.push_back(32'h0000_0042);
    run_frame(q, 5'd0, 100, 100);

    // Reset mid-frame with one entry buffered.
    cfg(32'd5, 5'd0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h0010_0000;
    step();
    s_tdata  = 32'd3;
    m_tready = 1'b1;
    step();
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    chk("t6_valid_pre", 32'(m_tvalid), 32'd1);
    chk("t6_data_pre", 32'(m_tdata), 32'd3);
    chk("t6_sat_pre", 32'(sat_cnt), 32'd1);
    axis_rst = 1'b1;
    step();
    axis_rst = 1'b0;
    chk("t6_valid", 32'(m_tvalid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sat", 32'(sat_cnt), 32'd0);
    chk("t6_ready", 32'(s_tready), 32'd0);
    q = {};
    q.push_back(32'h0000_0010);
    q.push_back(32'hFFFF_FFF0);
    run_frame(q, 5'd0, 100, 100);

    // Randomized frames against the reference model.
    for (int f = 0; f < 12; f++) begin
      int          len;
      logic [16:0] s17;
      logic [4:0]  sh;
      len = int'($urandom_range(1, 20));
      sh  = 5'($urandom_range(0, 31));
      q = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(1) == 0) begin
          q.push_back($urandom);
        end else begin
          s17 = 17'($urandom);
          q.push_back({{15{s17[16]}}, s17});
        end
      end
      run_frame(q, sh, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
